// File: rtl/bresenham_line_engine_if.sv
// Segment request / pixel stream bundle for the Bresenham line engine.
// master: the controller side that issues segments and consumes pixels.
// slave: the engine itself.
interface bresenham_line_engine_if #(
  parameter int unsigned COORD_W = 8
) ();

  logic               draw_en;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               pixel_ready;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               pixel_valid;
  logic               draw_done;
  logic               busy;

  modport master (
    output draw_en, x0, y0, x1, y1, pixel_ready,
    input  pixel_x, pixel_y, pixel_valid, draw_done, busy
  );

  modport slave (
    input  draw_en, x0, y0, x1, y1, pixel_ready,
    output pixel_x, pixel_y, pixel_valid, draw_done, busy
  );

endinterface

// File: rtl/bresenham_line_engine.sv
// Integer Bresenham line rasterizer: one segment per draw_en, one pixel per
// accepted valid/ready transfer, single-cycle draw_done after the last pixel.
module bresenham_line_engine #(
  parameter int unsigned COORD_W = 8
) (
  input logic                      clk,
  input logic                      n_rst,  // active-high asynchronous reset
  bresenham_line_engine_if.slave   bus
);

  localparam int unsigned SW = COORD_W + 2;  // dx, dy, err
  localparam int unsigned EW = COORD_W + 3;  // e2 = 2*err

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPlot,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  cx_q, cx_d;
  logic [COORD_W-1:0]  cy_q, cy_d;
  logic [COORD_W-1:0]  x1_q, x1_d;
  logic [COORD_W-1:0]  y1_q, y1_d;
  logic signed [SW-1:0] dx_q, dx_d;
  logic signed [SW-1:0] dy_q, dy_d;
  logic signed [SW-1:0] err_q, err_d;
  logic                sx_neg_q, sx_neg_d;
  logic                sy_neg_q, sy_neg_d;

  logic [COORD_W-1:0]  adx, ady;
  logic signed [SW-1:0] dx_new, dy_new;
  logic signed [EW-1:0] e2;
  logic                step_x, step_y;
  logic signed [SW-1:0] add_x, add_y;
  logic                at_end;
  logic                xfer;

  localparam logic [COORD_W-1:0] One = COORD_W'(1);

  // State and datapath registers; reset clears everything and abandons a line.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  // Next-state logic and Bresenham step arithmetic.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    // Setup-time deltas; cx/cy hold the start point at that time.
    adx    = (x1_q >= cx_q) ? (x1_q - cx_q) : (cx_q - x1_q);
    ady    = (y1_q >= cy_q) ? (y1_q - cy_q) : (cy_q - y1_q);
    dx_new = $signed(SW'(adx));
    dy_new = -$signed(SW'(ady));

    // Both step decisions use the same e2.
    e2     = $signed({err_q, 1'b0});
    step_x = (e2 >= EW'(dy_q));
    step_y = (e2 <= EW'(dx_q));
    add_x  = step_x ? dy_q : '0;
    add_y  = step_y ? dx_q : '0;

    at_end = (cx_q == x1_q) && (cy_q == y1_q);
    xfer   = (state_q == StPlot) && bus.pixel_ready;

    unique case (state_q)
      StIdle: begin
        if (bus.draw_en) begin
          // Start point goes straight into the current-pixel registers.
          cx_d    = bus.x0;
          cy_d    = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        dx_d     = dx_new;
        dy_d     = dy_new;
        err_d    = dx_new + dy_new;
        sx_neg_d = !(cx_q < x1_q);
        sy_neg_d = !(cy_q < y1_q);
        state_d  = StPlot;
      end
      StPlot: begin
        if (xfer) begin
          if (at_end) begin
            state_d = StDone;
          end else begin
            err_d = err_q + add_x + add_y;
            if (step_x) cx_d = sx_neg_q ? (cx_q - One) : (cx_q + One);
            if (step_y) cy_d = sy_neg_q ? (cy_q - One) : (cy_q + One);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are taken directly from registers.
  assign bus.pixel_x     = cx_q;
  assign bus.pixel_y     = cy_q;
  assign bus.pixel_valid = (state_q == StPlot);
  assign bus.draw_done   = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Pixel-generating line rasterizer that sits downstream of `bresenham_controller`. It accepts one line segment (x0,y0)→(x1,y1) per `draw_en` request and emits every pixel on that segment in order using integer Bresenham stepping, one pixel per accepted handshake. After the last pixel it returns a single-cycle `draw_done`, which the controller uses to advance to the next polygon edge. Pixel output feeds the frame-buffer write stage through a valid/ready handshake.

## Interface
- `COORD_W`, default 8: width of every coordinate.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous reset, active-high (1 = reset); port name kept for compatibility with the controller.
- `draw_en`  in  1  start request; sampled only in IDLE.
- `x0`, `y0`, `x1`, `y1`  in  COORD_W each  segment endpoints, unsigned; sampled with `draw_en`.
- `pixel_ready`  in  1  downstream accepts the current pixel.
- `pixel_x`, `pixel_y`  out  COORD_W each  current pixel coordinate.
- `pixel_valid`  out  1  `pixel_x`/`pixel_y` hold a pixel to write.
- `draw_done`  out  1  one-cycle pulse after the final pixel is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, PLOT, DONE.
- IDLE: `draw_en`=1 latches x0,y0,x1,y1 into internal registers, then go to SETUP. Endpoint inputs are not used after latching.
- SETUP (1 cycle):
  - dx = |x1−x0|, dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1. sy = +1 if y0<y1, else −1.
  - err = dx+dy. Current pixel (cx,cy) = (x0,y0).
  - Go to PLOT.
- PLOT: `pixel_valid`=1 and outputs show (cx,cy). The pixel transfers when `pixel_ready`=1.
  - On transfer with (cx,cy)==(x1,y1): go to DONE.
  - On transfer otherwise: e2 = 2·err.
    - If e2 ≥ dy: err += dy, cx += sx.
    - If e2 ≤ dx: err += dx, cy += sy.
    - Both conditions are evaluated against the same e2, and both updates apply in the same cycle. Stay in PLOT.
  - No transfer: every PLOT register holds.
- DONE (1 cycle): `draw_done`=1, then go to IDLE.
- Arithmetic: dx, dy and err are signed COORD_W+2 bits; e2 is signed COORD_W+3 bits. Coordinates never wrap, because stepping stops at the endpoint.
- Pixel count = max(dx, −dy)+1. A degenerate segment (x0==x1 and y0==y1) emits exactly one pixel.
- `draw_en` is ignored in SETUP, PLOT and DONE. There is no queuing.
- Reset (asynchronous, any state) forces IDLE and clears all registers. A partial line is abandoned without `draw_done`.

## Timing
- Reset values: `pixel_x`=0, `pixel_y`=0, `pixel_valid`=0, `draw_done`=0, `busy`=0.
- `draw_en` sampled at edge k:
  - `busy`=1 from k+1.
  - First pixel valid from k+2.
- Throughput: one pixel per cycle while `pixel_ready`=1.
- Final pixel transferred at edge m:
  - `pixel_valid`=0 and `draw_done`=1 during cycle m→m+1.
  - IDLE from edge m+1, where `busy`=0 and a new `draw_en` may be sampled.
- Handshake rules:
  - `pixel_x`, `pixel_y` and `pixel_valid` are registered.
  - Once `pixel_valid` is high, it and the coordinates stay stable until transfer.
  - `pixel_ready` may toggle freely and has no combinational path to outputs other than through the registered state update.
- `draw_done` and `pixel_valid` are never high in the same cycle.

## Test plan
- Horizontal line (0,0)→(3,0), `pixel_ready` held 1 → pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles. `draw_done` pulses for 1 cycle after the last pixel. Total from `draw_en` to `draw_done` = 6 cycles.
- Shallow line (0,0)→(4,2) → pixels (0,0),(1,1),(2,1),(3,2),(4,2).
- Reverse steep line (5,5)→(3,0) → 6 pixels. y decreases by exactly 1 per pixel, x is non-increasing and ends at 3. The first pixel is (5,5) and the last is (3,0).
- Degenerate segment (7,9)→(7,9) → exactly one pixel (7,9), then `draw_done`.
- Backpressure on (0,0)→(2,2): hold `pixel_ready`=0 for 3 cycles while (1,1) is valid → (1,1) stays stable and valid. The sequence completes as (0,0),(1,1),(2,2). A `draw_en` pulse mid-line is ignored.
- Assert `n_rst` during PLOT of (0,0)→(10,0) at pixel (4,0) → outputs drop to reset values immediately and no `draw_done` occurs. A subsequent `draw_en` with (1,1)→(2,1) yields (1,1),(2,1).
